// File: rtl/bcd_scan_disp.sv
// Display stage for a 16-bit counter: latches a binary value on an update strobe,
// converts it to BCD with a sequential double-dabble engine, and scans the four low
// digits onto a common-anode 7-segment display.
`timescale 1ns/1ps

module bcd_scan_disp #(
  parameter int unsigned SCAN_DIV = 1000,  // clocks per digit slot, >= 2
  parameter bit          LZB      = 1'b1   // 1 = blank leading zeros
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        upd,
  output logic        busy,
  output logic [15:0] bcd,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  // Conversion engine state
  logic [1:0]  state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [19:0] acc_q, acc_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic        pend_q, pend_d;
  logic [15:0] pend_val_q, pend_val_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;

  // Scan state
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    digit;
  logic          blank;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the doubling shift
  function automatic logic [19:0] add3(input logic [19:0] a);
    logic [19:0] r;
    r = a;
    for (int i = 0; i < 5; i++) begin
      if (a[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [19:0] acc_adj;
  assign acc_adj = add3(acc_q);

  // Conversion FSM next-state and pending-update capture
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    acc_d      = acc_q;
    bitcnt_d   = bitcnt_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;

    case (state_q)
      StIdle: begin
        if (upd) begin
          shreg_d  = din;
          acc_d    = '0;
          bitcnt_d = '0;
          pend_d   = 1'b0;
          state_d  = StShift;
        end else if (pend_q) begin
          // An update that landed in the final DONE cycle is picked up here
          shreg_d  = pend_val_q;
          acc_d    = '0;
          bitcnt_d = '0;
          pend_d   = 1'b0;
          state_d  = StShift;
        end
      end
      StShift: begin
        {acc_d, shreg_d} = {acc_adj[18:0], shreg_q, 1'b0};
        bitcnt_d = bitcnt_q + 4'd1;
        if (bitcnt_q == 4'd15) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d = acc_q[15:0];
        ovf_d = |acc_q[19:16];
        if (pend_q) begin
          shreg_d  = pend_val_q;
          acc_d    = '0;
          bitcnt_d = '0;
          pend_d   = 1'b0;
          state_d  = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A strobe while busy overrides any clear above; latest value wins
    if (upd && (state_q != StIdle)) begin
      pend_d     = 1'b1;
      pend_val_d = din;
    end
  end

  // Conversion registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      acc_q      <= '0;
      bitcnt_q   <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      acc_q      <= acc_d;
      bitcnt_q   <= bitcnt_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  // Prescaler and digit index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
    end else if (presc_q == PRE_LAST) begin
      presc_q <= '0;
      idx_q   <= idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Select the active digit and decide whether it is a blanked leading zero
  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    unique case (idx_q)
      2'd0: begin
        digit = bcd_q[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        digit = bcd_q[7:4];
        blank = LZB && (bcd_q[15:4] == 12'd0);
      end
      2'd2: begin
        digit = bcd_q[11:8];
        blank = LZB && (bcd_q[15:8] == 8'd0);
      end
      2'd3: begin
        digit = bcd_q[15:12];
        blank = LZB && (bcd_q[15:12] == 4'd0);
      end
      default: ;
    endcase
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? 7'h7F : seg_decode(digit);
  end

  // Registered display drive so an and seg always change together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_q  <= 4'b1111;
      seg_q <= 7'h7F;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_bcd_scan_disp.sv
// Self-checking bench for bcd_scan_disp: directed sequences plus random conversions,
// checked against a decimal-arithmetic display model.
`timescale 1ns/1ps

module tb_bcd_scan_disp;

  localparam int unsigned DIV = 4;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        upd;
  logic        busy, busy_b;
  logic [15:0] bcd, bcd_b;
  logic        ovf, ovf_b;
  logic [3:0]  an, an_b;
  logic [6:0]  seg, seg_b;

  int total = 0;
  int bad   = 0;
  int unsigned cyc;
  int unsigned cur;  // value the display should currently be committed to

  bcd_scan_disp #(.SCAN_DIV(DIV), .LZB(1'b1)) u_dut (
    .clk(clk), .rst(rst), .din(din), .upd(upd), .busy(busy),
    .bcd(bcd), .ovf(ovf), .an(an), .seg(seg)
  );

  bcd_scan_disp #(.SCAN_DIV(DIV), .LZB(1'b0)) u_dut_nolzb (
    .clk(clk), .rst(rst), .din(din), .upd(upd), .busy(busy_b),
    .bcd(bcd_b), .ovf(ovf_b), .an(an_b), .seg(seg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clocks since reset release; drives the expected scan position
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_bcd(input int unsigned v);
    int unsigned w;
    w = v % 10000;
    return 16'((w / 1000) * 4096 + ((w / 100) % 10) * 256 + ((w / 10) % 10) * 16 + w % 10);
  endfunction

  function automatic logic [6:0] model_seg(input int unsigned v, input int unsigned d,
                                           input bit lzb);
    logic [6:0]  tab [10];
    int unsigned pw [4];
    int unsigned w;
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    pw  = '{1, 10, 100, 1000};
    w   = v % 10000;
    if (lzb && d > 0 && w < pw[d]) return 7'h7F;
    return tab[(w / pw[d]) % 10];
  endfunction

  // Full conversion from idle with cycle-exact checks around the commit edge
  task automatic convert(input int unsigned v);
    @(negedge clk);
    din = 16'(v);
    upd = 1'b1;
    @(negedge clk);  // after edge 0
    upd = 1'b0;
    chk("busy_start", busy, 1);
    repeat (16) @(negedge clk);  // after edge 16
    chk("busy_edge16", busy, 1);
    chk("bcd_hold_edge16", bcd, model_bcd(cur));
    @(negedge clk);  // after edge 17
    cur = v;
    chk("bcd_commit", bcd, model_bcd(v));
    chk("ovf_commit", ovf, (v >= 10000) ? 1 : 0);
    chk("busy_end", busy, 0);
    chk("bcd_commit_b", bcd_b, model_bcd(v));
    chk("ovf_commit_b", ovf_b, (v >= 10000) ? 1 : 0);
    chk("busy_end_b", busy_b, 0);
  endtask

  task automatic scan_check(input int n);
    int unsigned k;
    logic [3:0]  one;
    logic [3:0]  exp_an;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k      = ((cyc - 1) / DIV) % 4;
      one    = 4'b0001;
      exp_an = ~(one << k);
      chk("scan_an", an, exp_an);
      chk("scan_seg_lzb", seg, model_seg(cur, k, 1'b1));
      chk("scan_an_b", an_b, exp_an);
      chk("scan_seg_nolzb", seg_b, model_seg(cur, k, 1'b0));
    end
  endtask

  // Called at a negedge; returns one negedge later with the strobe sampled
  task automatic pulse(input int unsigned v);
    din = 16'(v);
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    upd = 1'b0;
    din = '0;
    cur = 0;

    // T1: reset state and first scan slot
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'h7F);
    repeat (3) @(negedge clk);
    chk("rst_hold_an", an, 4'b1111);
    chk("rst_hold_seg", seg, 7'h7F);
    rst = 1'b1;
    @(negedge clk);
    chk("first_an", an, 4'b1110);
    chk("first_seg", seg, 7'h40);
    chk("first_seg_b", seg_b, 7'h40);
    scan_check(10);

    // T2 / T3: directed conversions
    convert(57);
    scan_check(18);
    convert(9999);
    convert(12345);
    scan_check(18);
    convert(65535);
    convert(0);
    convert(10005);
    scan_check(18);

    // T4: update while busy commits in-flight value then the pended one
    @(negedge clk);
    pulse(100);            // edge 0
    repeat (4) @(negedge clk);
    pulse(4321);           // edge 5
    repeat (11) @(negedge clk);
    chk("pend_hold", bcd, model_bcd(cur));
    @(negedge clk);        // edge 17
    chk("pend_first", bcd, 16'h0100);
    chk("pend_busy17", busy, 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("pend_busy_cont", busy, 1);
    end
    @(negedge clk);        // edge 34
    chk("pend_second", bcd, 16'h4321);
    chk("pend_idle", busy, 0);
    cur = 4321;

    // Two updates while busy: only the latest follows
    @(negedge clk);
    pulse(777);            // edge 0
    repeat (2) @(negedge clk);
    pulse(20);             // edge 3
    repeat (2) @(negedge clk);
    pulse(30);             // edge 6
    repeat (10) @(negedge clk);
    @(negedge clk);        // edge 17
    chk("two_first", bcd, 16'h0777);
    repeat (16) @(negedge clk);
    @(negedge clk);        // edge 34
    chk("two_latest", bcd, 16'h0030);
    chk("two_idle", busy, 0);
    repeat (20) @(negedge clk);
    chk("two_no_third", bcd, 16'h0030);
    chk("two_still_idle", busy, 0);
    cur = 30;

    // Update arriving in the DONE cycle is not lost
    @(negedge clk);
    pulse(111);            // edge 0
    repeat (16) @(negedge clk);
    pulse(222);            // edge 17
    chk("done_first", bcd, 16'h0111);
    repeat (25) @(negedge clk);
    chk("done_pended", bcd, 16'h0222);
    chk("done_idle", busy, 0);
    cur = 222;
    scan_check(8);

    // T6: reset in the middle of a conversion
    convert(65535);
    @(negedge clk);
    pulse(999);            // edge 0
    repeat (7) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_bcd", bcd, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_an", an, 4'b1111);
    chk("midrst_seg", seg, 7'h7F);
    @(negedge clk);
    rst = 1'b1;
    cur = 0;
    repeat (20) @(negedge clk);
    chk("postrst_bcd", bcd, 0);
    chk("postrst_busy", busy, 0);
    scan_check(8);

    // Random conversions with scan checks
    for (int i = 0; i < 20; i++) begin
      convert($urandom_range(0, 65535));
      scan_check(18);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
